// File: rtl/instruction_fetch_if.sv
// Bundle of the fetch unit's memory, redirect/halt control and decode handshake.
// IFETCH_MISALIGN_CHK_EN adds the sticky misalign_err flag to the bundle.
interface instruction_fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        halted;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
`ifdef IFETCH_MISALIGN_CHK_EN
    logic        misalign_err;

    modport master (
        output imem_addr, halted, inst_valid, inst_out, inst_pc, misalign_err,
        input  imem_inst, redirect_valid, redirect_pc, halt_req, inst_ready
    );
    modport slave (
        input  imem_addr, halted, inst_valid, inst_out, inst_pc, misalign_err,
        output imem_inst, redirect_valid, redirect_pc, halt_req, inst_ready
    );
`else
    modport master (
        output imem_addr, halted, inst_valid, inst_out, inst_pc,
        input  imem_inst, redirect_valid, redirect_pc, halt_req, inst_ready
    );
    modport slave (
        input  imem_addr, halted, inst_valid, inst_out, inst_pc,
        output imem_inst, redirect_valid, redirect_pc, halt_req, inst_ready
    );
`endif
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: owns the PC, issues reads to a one-cycle synchronous
// instruction memory, and buffers returned words in a 2-entry skid FIFO
// toward decode. Redirects flush everything; halt_req drains then stops.
// Optional: IFETCH_MISALIGN_CHK_EN adds a sticky misaligned-redirect flag.
//
// state   | meaning
// S_RUN   | issuing fetches whenever the FIFO credit allows
// S_DRAIN | halt requested; no issue, in-flight word and FIFO drain out
// S_HALTED| drained and stopped; only a redirect restarts fetching
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 32
) (
    input logic               clock,
    input logic               reset_n,
    instruction_fetch_if.master bus
);
    // Byte-address range of the memory, word-aligned.
    localparam logic [31:0] ADDR_MASK = ((32'(MEM_WORDS) << 2) - 32'd1) & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc;
    logic        inflight_valid;
    logic [31:0] inflight_pc;
    logic [31:0] head_inst, head_pc, tail_inst, tail_pc;
    logic [1:0]  count;
    logic        pop, push, issue;
    logic [2:0]  occupancy;

    assign pop  = (count != 2'd0) & bus.inst_ready;
    assign push = inflight_valid;
    // Slots still claimed after this cycle; issuing is safe only if one stays free.
    assign occupancy = {1'b0, count} + {2'b00, inflight_valid} - {2'b00, pop};

    assign bus.imem_addr  = fetch_pc;
    assign bus.inst_valid = (count != 2'd0);
    assign bus.inst_out   = head_inst;
    assign bus.inst_pc    = head_pc;
    assign bus.halted     = (state == S_HALTED);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_RUN;
        else          state <= state_nxt;
    end

    // Next state and fetch-issue decision; redirect overrides everything.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        if (bus.redirect_valid) begin
            state_nxt = S_RUN;
        end else begin
            case (state)
                S_RUN: begin
                    issue = (occupancy <= 3'd1);
                    if (bus.halt_req) state_nxt = S_DRAIN;
                end
                S_DRAIN: begin
                    if (!bus.halt_req)                            state_nxt = S_RUN;
                    else if ((count == 2'd0) && !inflight_valid)  state_nxt = S_HALTED;
                end
                S_HALTED: state_nxt = S_HALTED;
                default:  state_nxt = S_RUN;
            endcase
        end
    end

    // PC and in-flight read tracking.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc       <= RESET_PC;
            inflight_valid <= 1'b0;
            inflight_pc    <= 32'd0;
        end else if (bus.redirect_valid) begin
            fetch_pc       <= bus.redirect_pc & ADDR_MASK;
            inflight_valid <= 1'b0;
        end else begin
            inflight_valid <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= (fetch_pc + 32'd4) & ADDR_MASK;
            end
        end
    end

    // Two-entry skid FIFO; head feeds decode, returning word lands behind it.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count     <= 2'd0;
            head_inst <= 32'd0;
            head_pc   <= 32'd0;
            tail_inst <= 32'd0;
            tail_pc   <= 32'd0;
        end else if (bus.redirect_valid) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head_inst <= bus.imem_inst;
                        head_pc   <= inflight_pc;
                    end else begin
                        tail_inst <= bus.imem_inst;
                        tail_pc   <= inflight_pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_inst <= tail_inst;
                    head_pc   <= tail_pc;
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_inst <= bus.imem_inst;
                        head_pc   <= inflight_pc;
                    end else begin
                        head_inst <= tail_inst;
                        head_pc   <= tail_pc;
                        tail_inst <= bus.imem_inst;
                        tail_pc   <= inflight_pc;
                    end
                end
                default: count <= count;
            endcase
        end
    end

`ifdef IFETCH_MISALIGN_CHK_EN
    logic misalign_q;

    // Sticky record of any redirect target that was not word-aligned.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            misalign_q <= 1'b0;
        else if (bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00))
            misalign_q <= 1'b1;
    end

    assign bus.misalign_err = misalign_q;
`endif
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch initiator for the MIPS single-cycle/pipelined datapath. It owns the program counter and drives the byte address into the synchronous instruction memory, which returns the word one cycle later. It tracks the in-flight read, buffers returned words in a 2-entry skid FIFO toward decode with a valid/ready handshake, and handles branch/jump redirects and halt/drain.

## Interface
- RESET_PC, 32'h0000_0000: byte address fetched first after reset; must be word-aligned.
- MEM_WORDS, 32: instruction memory depth in words; power of two; fetch addresses wrap modulo MEM_WORDS*4.

- clock  in  1  rising-edge clock shared with instruction memory
- reset_n  in  1  asynchronous, active-low reset
- imem_addr  out  32  byte address to memory PC input; equals fetch_pc register
- imem_inst  in  32  memory read data; valid the cycle after the edge that sampled imem_addr
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  32  redirect target byte address
- halt_req  in  1  level; stop issuing new fetches
- halted  out  1  high when drained and stopped
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decode accepts head
- inst_out  out  32  instruction at FIFO head
- inst_pc  out  32  byte address of inst_out

## Operation
- Registers: fetch_pc, inflight_valid, inflight_pc, 2-entry FIFO {inst, pc}, count (0..2), state.
- pop = inst_valid & inst_ready. push = inflight_valid (imem_inst captured with inflight_pc).
- issue = (state==RUN) & ~redirect_valid & (count + inflight_valid - pop <= 1).
- On issue: inflight_valid<=1, inflight_pc<=fetch_pc, fetch_pc<=(fetch_pc+4) mod (MEM_WORDS*4). Otherwise inflight_valid<=0, fetch_pc holds; memory re-reads the same address harmlessly.
- Push and pop in the same cycle: count unchanged, order preserved. FIFO never overflows due to the credit rule.
- Redirect (highest priority): fetch_pc<=redirect_pc with bits[1:0] cleared, masked to memory range; FIFO flushed (count<=0); inflight_valid<=0 and its returning word dropped; no issue that cycle; state<=RUN regardless of current state.
- States: RUN -> DRAIN when halt_req (and no redirect). DRAIN: no issue; pops and pushes continue; -> HALTED when count==0 and inflight_valid==0 after the edge. HALTED: halted=1, no issue; exit only on redirect_valid. Deasserting halt_req in DRAIN returns to RUN.
- Reset values: fetch_pc=RESET_PC, imem_addr=RESET_PC, inflight_valid=0, count=0, inst_valid=0, inst_out=0, inst_pc=0, halted=0, state=RUN. Mid-operation reset discards all buffered and in-flight words immediately.

## Timing
- Issue edge E: memory samples imem_addr. Word pushed at E+1. inst_valid high after E+1.
- First instruction after reset release: inst_valid high after the 2nd rising edge.
- Sustained throughput: 1 instruction/cycle with inst_ready held high.
- Redirect at edge R: inst_valid low after R; first target word valid after R+2.
- inst_valid/inst_out/inst_pc stable while inst_valid & ~inst_ready.
- halted asserts the edge after drain completes; deasserts on the redirect edge.

## Configuration
- IFETCH_MISALIGN_CHK_EN defined: extra port misalign_err (out, 1) is sticky, set on any redirect with redirect_pc[1:0]!=0, cleared only by reset. The redirect is still taken with the low bits cleared.
- Not defined: port absent; low bits are silently cleared.

## Test plan
- Reset release, RESET_PC=0, inst_ready=1, memory words 3..5 = lw/lw/add: inst_pc sequence 0,4,8,12,16,20 one per cycle from the 2nd edge, with inst_out matching memory.
- inst_ready=0 for 5 cycles: count saturates at 2, issue stops, head held at the same pc. Releasing ready delivers in order with no loss or duplicate.
- Redirect to 0x14 while FIFO full and a read is in flight: inst_valid drops for 2 cycles, then inst_pc=0x14 with inst_out=memory[5]; no stale word appears.
- Fetch past 0x7C with MEM_WORDS=32: next inst_pc=0x00.
- halt_req with 2 buffered words, ready=1: both delivered, then halted=1 and no further issue. Redirect to 0x0C restarts with inst_pc=0x0C.
- With IFETCH_MISALIGN_CHK_EN, redirect_pc=0x0E: misalign_err=1 (sticky), fetch resumes at 0x0C.
